// File: rtl/wt_cache_pkg.sv
// Shared state encoding and default geometry for the write-through cache controller.
package wt_cache_pkg;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_INDEX_W = 7;
  localparam int DEF_PERF_W  = 16;
  localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W;
  localparam int DEF_LINES   = 1 << DEF_INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;
endpackage

// File: rtl/wt_cache_array.sv
// Direct-mapped valid/tag/data store: combinational lookup, one write port, one-cycle clear-all.
// Writes land on the next edge; no backpressure, the controller owns sequencing.
module wt_cache_array
  import wt_cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_all,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit,
  output logic [DATA_W-1:0]  lookup_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign hit         = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
  assign lookup_data = data[lookup_index];
endmodule

// File: rtl/wt_cache_ctrl.sv
// Write-through, no-write-allocate direct-mapped cache controller; load hit 1 cycle, miss = mem latency + 1.
// Backpressure via registered stall: CPU requests are ignored while a memory transaction is outstanding.
module wt_cache_ctrl
  import wt_cache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int PERF_W  = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] word_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              mm_req,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic              mm_ack,
  input  logic [DATA_W-1:0] mm_rdata,
  output logic [PERF_W-1:0] hit_count,
  output logic [PERF_W-1:0] miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t state, state_n;
  logic              stall_n, rd_valid_n, mm_req_n, mm_we_n;
  logic [DATA_W-1:0] data_out_n, mm_wdata_n;
  logic [ADDR_W-1:0] mm_addr_n;
  logic [PERF_W-1:0] hit_n, miss_n;

  logic               hit, clear_all, wr_en;
  logic [DATA_W-1:0]  lookup_data, wr_data;
  logic [INDEX_W-1:0] wr_index;
  logic [TAG_W-1:0]   wr_tag;

  wire [INDEX_W-1:0] idx = word_address[INDEX_W-1:0];
  wire [TAG_W-1:0]   tag = word_address[ADDR_W-1:INDEX_W];

  wt_cache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
    .clk          (clk),
    .reset        (reset),
    .clear_all    (clear_all),
    .lookup_index (idx),
    .lookup_tag   (tag),
    .hit          (hit),
    .lookup_data  (lookup_data),
    .wr_en        (wr_en),
    .wr_index     (wr_index),
    .wr_tag       (wr_tag),
    .wr_data      (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      stall      <= 1'b0;
      data_out   <= '0;
      rd_valid   <= 1'b0;
      mm_req     <= 1'b0;
      mm_we      <= 1'b0;
      mm_addr    <= '0;
      mm_wdata   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state      <= state_n;
      stall      <= stall_n;
      data_out   <= data_out_n;
      rd_valid   <= rd_valid_n;
      mm_req     <= mm_req_n;
      mm_we      <= mm_we_n;
      mm_addr    <= mm_addr_n;
      mm_wdata   <= mm_wdata_n;
      hit_count  <= hit_n;
      miss_count <= miss_n;
    end
  end

  always_comb begin
    state_n    = state;
    stall_n    = stall;
    data_out_n = data_out;
    rd_valid_n = 1'b0;
    mm_req_n   = mm_req;
    mm_we_n    = mm_we;
    mm_addr_n  = mm_addr;
    mm_wdata_n = mm_wdata;
    hit_n      = hit_count;
    miss_n     = miss_count;
    clear_all  = 1'b0;
    wr_en      = 1'b0;
    wr_index   = idx;
    wr_tag     = tag;
    wr_data    = data_in;

    unique case (state)
      IDLE: begin
        if (flush) begin
          clear_all = 1'b1;
        end else if (mem_read) begin
          if (hit) begin
            data_out_n = lookup_data;
            rd_valid_n = 1'b1;
            hit_n      = (hit_count == '1) ? hit_count : hit_count + 1'b1;
          end else begin
            stall_n   = 1'b1;
            mm_req_n  = 1'b1;
            mm_we_n   = 1'b0;
            mm_addr_n = word_address;
            miss_n    = (miss_count == '1) ? miss_count : miss_count + 1'b1;
            state_n   = RD_MISS;
          end
        end else if (mem_write) begin
          // Store hit refreshes the line in place; a miss leaves the cache untouched.
          wr_en      = hit;
          stall_n    = 1'b1;
          mm_req_n   = 1'b1;
          mm_we_n    = 1'b1;
          mm_addr_n  = word_address;
          mm_wdata_n = data_in;
          state_n    = WR_THRU;
        end
      end
      RD_MISS: begin
        if (mm_ack) begin
          wr_en      = 1'b1;
          wr_index   = mm_addr[INDEX_W-1:0];
          wr_tag     = mm_addr[ADDR_W-1:INDEX_W];
          wr_data    = mm_rdata;
          data_out_n = mm_rdata;
          rd_valid_n = 1'b1;
          mm_req_n   = 1'b0;
          stall_n    = 1'b0;
          state_n    = IDLE;
        end
      end
      WR_THRU: begin
        if (mm_ack) begin
          mm_req_n = 1'b0;
          stall_n  = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // An ack coinciding with reset must not fill the line.
    if (reset) begin
      wr_en     = 1'b0;
      clear_all = 1'b0;
    end
  end
endmodule

// File: tb/tb_wt_cache_ctrl.sv
// Scoreboard bench: directed loads/stores/flush against a latency-3 memory model, plus a PERF_W=2 twin.
module tb_wt_cache_ctrl;
  localparam int MEM_LAT = 3;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } mm_exp_t;

  logic        clk = 1'b0;
  logic        reset, mem_read, mem_write, flush;
  logic [9:0]  word_address;
  logic [31:0] data_in;
  logic        mm_ack;
  logic [31:0] mm_rdata;

  logic        stall, rd_valid, mm_req, mm_we;
  logic [31:0] data_out, mm_wdata;
  logic [9:0]  mm_addr;
  logic [15:0] hit_count, miss_count;

  logic        stall2, rd_valid2, mm_req2, mm_we2;
  logic [31:0] data_out2, mm_wdata2;
  logic [9:0]  mm_addr2;
  logic [1:0]  hit_count2, miss_count2;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rd[$];
  mm_exp_t     exp_mm[$];
  logic [31:0] mem[int];
  bit          mem_auto, force_ack, mon_mm_en;

  always #5 clk = ~clk;

  wt_cache_ctrl #(.ADDR_W(10), .DATA_W(32), .INDEX_W(7), .PERF_W(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .word_address(word_address), .data_in(data_in), .flush(flush),
    .stall(stall), .data_out(data_out), .rd_valid(rd_valid),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_ack(mm_ack), .mm_rdata(mm_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  wt_cache_ctrl #(.ADDR_W(10), .DATA_W(32), .INDEX_W(7), .PERF_W(2)) dut_sat (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .word_address(word_address), .data_in(data_in), .flush(flush),
    .stall(stall2), .data_out(data_out2), .rd_valid(rd_valid2),
    .mm_req(mm_req2), .mm_we(mm_we2), .mm_addr(mm_addr2), .mm_wdata(mm_wdata2),
    .mm_ack(mm_ack), .mm_rdata(mm_rdata),
    .hit_count(hit_count2), .miss_count(miss_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: acks the (MEM_LAT+1)th cycle of a held request.
  initial begin
    int cnt;
    cnt = 0;
    mm_ack = 1'b0;
    mm_rdata = '0;
    mem[10'h0A5] = 32'hDEAD;
    mem[10'h125] = 32'hBEEF;
    forever begin
      @(posedge clk);
      #1;
      mm_ack = 1'b0;
      if (force_ack) begin
        mm_ack = 1'b1;
        mm_rdata = 32'h0BAD;
        cnt = 0;
      end else if (mem_auto && mm_req === 1'b1 && reset === 1'b0) begin
        cnt++;
        if (cnt > MEM_LAT) begin
          mm_ack = 1'b1;
          if (mm_we) mem[int'(mm_addr)] = mm_wdata;
          else mm_rdata = mem.exists(int'(mm_addr)) ? mem[int'(mm_addr)] : 32'h0;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Read-data monitor.
  initial forever begin
    @(negedge clk);
    if (rd_valid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", 32'(rd_valid), 32'h0);
      end else begin
        logic [31:0] e;
        e = exp_rd.pop_front();
        chk("rd_data", data_out, e);
        chk("rd_data_sat", data_out2, e);
        chk("rd_valid_sat", 32'(rd_valid2), 32'h1);
      end
    end
  end

  // Memory-request monitor: request must match and stay stable until ack.
  initial forever begin
    @(negedge clk);
    if (mon_mm_en && mm_req === 1'b1) begin
      if (exp_mm.size() == 0) begin
        chk("mm_unexpected", 32'(mm_req), 32'h0);
      end else begin
        chk("mm_we", 32'(mm_we), 32'(exp_mm[0].we));
        chk("mm_addr", 32'(mm_addr), 32'(exp_mm[0].addr));
        chk("mm_we_sat", 32'(mm_we2), 32'(exp_mm[0].we));
        chk("mm_addr_sat", 32'(mm_addr2), 32'(exp_mm[0].addr));
        if (exp_mm[0].we) begin
          chk("mm_wdata", mm_wdata, exp_mm[0].wdata);
          chk("mm_wdata_sat", mm_wdata2, exp_mm[0].wdata);
        end
        if (mm_ack) void'(exp_mm.pop_front());
      end
    end
  end

  task automatic wait_idle(input string name, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (stall !== 1'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] exp, input bit is_hit);
    exp_rd.push_back(exp);
    if (!is_hit) exp_mm.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
    mem_read = 1'b1;
    word_address = a;
    @(negedge clk);
    mem_read = 1'b0;
    if (is_hit) chk("hit_no_mm_req", 32'(mm_req), 32'h0);
    wait_idle(is_hit ? "load_hit_stall" : "load_miss_stall", is_hit ? 0 : MEM_LAT + 1);
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d);
    exp_mm.push_back('{we: 1'b1, addr: a, wdata: d});
    mem_write = 1'b1;
    word_address = a;
    data_in = d;
    @(negedge clk);
    mem_write = 1'b0;
    data_in = 32'h0;
    wait_idle("store_stall", MEM_LAT + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    word_address = '0; data_in = '0;
    mem_auto = 1'b1; force_ack = 1'b0; mon_mm_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_mm_req", 32'(mm_req), 32'h0);
    chk("rst_mm_we", 32'(mm_we), 32'h0);
    chk("rst_mm_addr", 32'(mm_addr), 32'h0);
    chk("rst_mm_wdata", mm_wdata, 32'h0);
    chk("rst_hits", 32'(hit_count), 32'h0);
    chk("rst_misses", 32'(miss_count), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    load(10'h0A5, 32'hDEAD, 1'b0);
    chk("miss_cnt_1", 32'(miss_count), 32'd1);
    chk("miss_cnt_sat_1", 32'(miss_count2), 32'd1);
    load(10'h0A5, 32'hDEAD, 1'b1);
    chk("hit_cnt_1", 32'(hit_count), 32'd1);

    store(10'h0A5, 32'h1234);
    load(10'h0A5, 32'h1234, 1'b1);
    chk("hit_cnt_2", 32'(hit_count), 32'd2);

    load(10'h125, 32'hBEEF, 1'b0);
    load(10'h0A5, 32'h1234, 1'b0);
    chk("miss_cnt_3", 32'(miss_count), 32'd3);

    store(10'h300, 32'h7);
    load(10'h300, 32'h7, 1'b0);
    load(10'h125, 32'hBEEF, 1'b0);
    load(10'h125, 32'hBEEF, 1'b1);

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_stall", 32'(stall), 32'h0);
    chk("flush_mm_req", 32'(mm_req), 32'h0);
    load(10'h125, 32'hBEEF, 1'b0);
    chk("hit_cnt_3", 32'(hit_count), 32'd3);
    chk("miss_cnt_6", 32'(miss_count), 32'd6);
    chk("hit_sat", 32'(hit_count2), 32'd3);
    chk("miss_sat", 32'(miss_count2), 32'd3);
    chk("data_out_held", data_out, 32'hBEEF);

    // Reset in the middle of a read miss, then a stray ack.
    mon_mm_en = 1'b0;
    mem_auto = 1'b0;
    mem_read = 1'b1;
    word_address = 10'h0A5;
    @(negedge clk);
    mem_read = 1'b0;
    chk("abort_stall_hi", 32'(stall), 32'h1);
    chk("abort_mm_req_hi", 32'(mm_req), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_stall_lo", 32'(stall), 32'h0);
    chk("abort_mm_req_lo", 32'(mm_req), 32'h0);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("late_ack_rd_valid", 32'(rd_valid), 32'h0);
    @(negedge clk);
    chk("late_ack_stall", 32'(stall), 32'h0);
    chk("late_ack_mm_req", 32'(mm_req), 32'h0);
    chk("late_ack_rd_valid2", 32'(rd_valid), 32'h0);
    chk("late_ack_data_out", data_out, 32'h0);
    mem_auto = 1'b1;
    mon_mm_en = 1'b1;

    load(10'h0A5, 32'h1234, 1'b0);
    chk("post_rst_miss", 32'(miss_count), 32'd1);
    chk("post_rst_hit", 32'(hit_count), 32'd0);

    repeat (2) @(negedge clk);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
    chk("mm_queue_empty", 32'(exp_mm.size()), 32'h0);
    chk("end_stall_sat", 32'(stall2), 32'h0);
    chk("end_mm_req_sat", 32'(mm_req2), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
